// File: rtl/dmem_pkg.sv
// Shared types for the data-memory load/store unit: RV32I funct3 codes,
// fault causes and FSM state encoding.
package dmem_pkg;

  typedef enum logic [2:0] {
    LB  = 3'd0,
    LH  = 3'd1,
    LW  = 3'd2,
    LBU = 3'd4,
    LHU = 3'd5
  } load_op_e;

  typedef enum logic [2:0] {
    SB = 3'd0,
    SH = 3'd1,
    SW = 3'd2
  } store_op_e;

  typedef enum logic [1:0] {
    CAUSE_NONE     = 2'd0,
    CAUSE_MISALIGN = 2'd1,
    CAUSE_ILLEGAL  = 2'd2
  } cause_e;

  typedef enum logic [1:0] {
    S_INIT,
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_e;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane steering for one access: byte enables, shifted store data,
// extended load data and fault classification (illegal beats misaligned).
module lsu_align
  import dmem_pkg::*;
(
  input  logic        we,
  input  logic [2:0]  funct3,
  input  logic [1:0]  off,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  be,
  output logic [31:0] wdata_sh,
  output logic [31:0] rdata_ext,
  output logic        err,
  output cause_e      cause
);

  logic [4:0]  shamt;
  logic [31:0] lane;

  assign shamt    = {off, 3'b000};
  assign lane     = rword >> shamt;
  assign wdata_sh = wdata << shamt;
  assign err      = (cause != CAUSE_NONE);

  always_comb begin
    be        = '0;
    rdata_ext = '0;
    cause     = CAUSE_NONE;
    if (we) begin
      case (funct3)
        SB:      be = 4'b0001 << off;
        SH:      if (off[0]) cause = CAUSE_MISALIGN; else be = 4'b0011 << off;
        SW:      if (off != 2'd0) cause = CAUSE_MISALIGN; else be = '1;
        default: cause = CAUSE_ILLEGAL;
      endcase
    end else begin
      case (funct3)
        LB:      rdata_ext = {{24{lane[7]}}, lane[7:0]};
        LBU:     rdata_ext = {24'b0, lane[7:0]};
        LH:      if (off[0]) cause = CAUSE_MISALIGN;
                 else rdata_ext = {{16{lane[15]}}, lane[15:0]};
        LHU:     if (off[0]) cause = CAUSE_MISALIGN;
                 else rdata_ext = {16'b0, lane[15:0]};
        LW:      if (off != 2'd0) cause = CAUSE_MISALIGN; else rdata_ext = lane;
        default: cause = CAUSE_ILLEGAL;
      endcase
    end
  end

endmodule

// File: rtl/dmem_lsu.sv
// RV32I MEM-stage load/store unit over a word-organised array with valid/ready
// handshakes, programmable latency, post-reset clear sweep and fault reporting.
module dmem_lsu
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_W         = 12,
  parameter int unsigned LATENCY        = 1,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic [1:0]        rsp_cause,
  output logic              init_busy
);

  localparam int unsigned WORD_W = ADDR_W - 2;
  localparam int unsigned DEPTH  = 2 ** WORD_W;
  localparam int unsigned CNT_W  = $clog2(LATENCY) + 1;

  state_e              state_q, state_n;
  logic [WORD_W-1:0]   clr_cnt_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                cap_we;
  logic [2:0]          cap_funct3;
  logic [ADDR_W-1:0]   cap_addr;
  logic [31:0]         cap_wdata;
  logic [31:0]         mem [DEPTH];

  logic                accept, enter_resp;
  logic                cur_we;
  logic [2:0]          cur_funct3;
  logic [ADDR_W-1:0]   cur_addr;
  logic [31:0]         cur_wdata;
  logic [WORD_W-1:0]   cur_word;
  logic [3:0]          be;
  logic [31:0]         wdata_sh, rdata_ext;
  logic                err;
  cause_e              cause;

  assign accept     = req_valid && req_ready;
  assign enter_resp = (state_n == S_RESP) && (state_q != S_RESP);
  assign cur_word   = cur_addr[ADDR_W-1:2];

  // With LATENCY==1 the access completes on the accepting edge, before the
  // capture registers load, so the live request is steered in from IDLE.
  always_comb begin
    if (state_q == S_IDLE) begin
      cur_we     = req_we;
      cur_funct3 = req_funct3;
      cur_addr   = req_addr;
      cur_wdata  = req_wdata;
    end else begin
      cur_we     = cap_we;
      cur_funct3 = cap_funct3;
      cur_addr   = cap_addr;
      cur_wdata  = cap_wdata;
    end
  end

  lsu_align u_align (
    .we        (cur_we),
    .funct3    (cur_funct3),
    .off       (cur_addr[1:0]),
    .wdata     (cur_wdata),
    .rword     (mem[cur_word]),
    .be        (be),
    .wdata_sh  (wdata_sh),
    .rdata_ext (rdata_ext),
    .err       (err),
    .cause     (cause)
  );

  always_comb begin
    state_n = state_q;
    case (state_q)
      S_INIT:  if (clr_cnt_q == '1) state_n = S_IDLE;
      S_IDLE:  if (accept) state_n = (LATENCY == 1) ? S_RESP : S_WAIT;
      S_WAIT:  if (cnt_q == CNT_W'(1)) state_n = S_RESP;
      S_RESP:  if (rsp_valid && rsp_ready) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q    <= CLEAR_ON_RESET ? S_INIT : S_IDLE;
      clr_cnt_q  <= '0;
      cnt_q      <= '0;
      cap_we     <= 1'b0;
      cap_funct3 <= '0;
      cap_addr   <= '0;
      cap_wdata  <= '0;
      req_ready  <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= '0;
      rsp_err    <= 1'b0;
      rsp_cause  <= '0;
      init_busy  <= CLEAR_ON_RESET;
    end else begin
      state_q   <= state_n;
      req_ready <= (state_n == S_IDLE);
      rsp_valid <= (state_n == S_RESP);
      init_busy <= (state_n == S_INIT);
      if (state_q == S_INIT) clr_cnt_q <= clr_cnt_q + WORD_W'(1);
      if (accept) begin
        cap_we     <= req_we;
        cap_funct3 <= req_funct3;
        cap_addr   <= req_addr;
        cap_wdata  <= req_wdata;
        cnt_q      <= CNT_W'(LATENCY - 1);
      end else if (state_q == S_WAIT) begin
        cnt_q <= cnt_q - CNT_W'(1);
      end
      if (enter_resp) begin
        rsp_err   <= err;
        rsp_cause <= cause;
        rsp_rdata <= (cur_we || err) ? '0 : rdata_ext;
      end
    end
  end

  // Array has no reset; only the INIT sweep clears it.
  always_ff @(posedge clk) begin
    if (state_q == S_INIT) begin
      mem[clr_cnt_q] <= '0;
    end else if (enter_resp && cur_we && !err) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (be[b]) mem[cur_word][8*b +: 8] <= wdata_sh[8*b +: 8];
      end
    end
  end

endmodule
